// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: received-byte stream (valid/ready) plus sticky error status and clear
interface uart_rx_fifo_if;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready;
  logic       ferr;
  logic       overrun;
  logic       clr_err;
  modport master (output rdata, rvalid, ferr, overrun, input rready, clr_err);
  modport slave (input rdata, rvalid, ferr, overrun, output rready, clr_err);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with input synchronizer, start-glitch rejection and byte FIFO
module uart_rx_fifo #(
  parameter int CLK_PER_HALF_BIT = 86,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           rxd,
  uart_rx_fifo_if.master bus
);
  localparam int CW = $clog2(2 * CLK_PER_HALF_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam logic [CW-1:0] HALF_END = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_END = CW'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [NW-1:0] DEPTH = NW'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  logic [1:0]    sync_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [NW-1:0] count_q, count_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          ferr_q, ferr_d, ovr_q, ovr_d;
  logic          rxd_s, push, frame_err, pop, full, wr;
  assign rxd_s = sync_q[1];
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = rxd_s ? IDLE : START;
      end
      START: if (cnt_q == HALF_END) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rxd_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == BIT_END) begin
        cnt_d   = '0;
        shift_d = {rxd_s, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
        state_d = (idx_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt_q == BIT_END) begin
        cnt_d     = '0;
        push      = rxd_s;
        frame_err = !rxd_s;
        state_d   = rxd_s ? IDLE : BRK;
      end
      BRK: begin
        cnt_d   = '0;
        state_d = rxd_s ? IDLE : BRK;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    pop    = (count_q != '0) && bus.rready;
    full   = count_q == DEPTH;
    wr     = push && (!full || pop);
    mem_d  = mem_q;
    if (wr) mem_d[wp_q] = shift_q;
    wp_d    = wp_q + AW'(wr);
    rp_d    = rp_q + AW'(pop);
    count_d = count_q + NW'(wr) - NW'(pop);
    rdata_d = mem_d[rp_d];
    ferr_d  = frame_err || (ferr_q && !bus.clr_err);
    ovr_d   = (push && full && !pop) || (ovr_q && !bus.clr_err);
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      mem_q   <= '{default: '0};
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      rdata_q <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  assign bus.rdata   = rdata_q;
  assign bus.rvalid  = count_q != '0;
  assign bus.ferr    = ferr_q;
  assign bus.overrun = ovr_q;
endmodule
